// File: rtl/sp_rom_pkg.sv
// Shared constants and content function for the sp_rom lookup table.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sp_rom_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    // Content of word `addr` in a table of `depth` populated words: each
    // word holds its own address; anything past the populated range is zero.
    // The caller truncates or zero-extends the 32-bit result to its width.
    function automatic logic [31:0] rom_word(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] val;
        val = '0;
        if (addr < depth) begin
            val = addr;
        end
        return val;
    endfunction

endpackage

// File: rtl/sp_rom_core.sv
// Combinational address-to-word lookup for sp_rom.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows addr continuously.
//   addr : word address
//   word : table content at addr (zero above DEPTH-1)
module sp_rom_core
    import sp_rom_pkg::*;
#(
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter int          DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    // Widen to at least 32 bits so narrow words truncate and wide words
    // zero-extend from the same slice.
    localparam int FULL_W = (DATA_W > 32) ? DATA_W : 32;

    logic [FULL_W-1:0] full;

    always_comb begin
        full = FULL_W'(rom_word(32'(addr), DEPTH));
        word = full[DATA_W-1:0];
    end

endmodule

// File: rtl/sp_rom.sv
// Single-port read-only table: word k = k, registered read, enable-gated output.
// Latency: 1 cycle addr->o_dout; 0 cycles i_en->o_dout/o_valid.
// Backpressure: none; a new word is captured every edge, i_en only gates visibility.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_en    : output enable (combinational gate on o_dout / o_valid)
//   i_addr  : read address, sampled every rising edge
//   o_dout  : registered word, zero while disabled or in reset
//   o_valid : registered word is real (post-reset edge seen) and i_en=1
module sp_rom
    import sp_rom_pkg::*;
#(
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter int          DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_valid
);

    logic [DATA_W-1:0] rom_dat;
    logic [DATA_W-1:0] data_q;
    logic              fill_q;

    sp_rom_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .addr (i_addr),
        .word (rom_dat)
    );

    // Capture runs while disabled too, so the word for a held address is
    // already present the moment i_en rises.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
            fill_q <= 1'b0;
        end else begin
            data_q <= rom_dat;
            fill_q <= 1'b1;
        end
    end

    assign o_dout  = i_en ? data_q : '0;
    assign o_valid = i_en & fill_q;

endmodule

// File: tb/tb_sp_rom.sv
module tb_sp_rom;
    import sp_rom_pkg::*;

    localparam int          D5     = 5;
    localparam int          W_AW   = 5;
    localparam int          W_DW   = 4;

    if (!(D5 >= 1 && D5 <= 2**3)) begin : g_bad_depth
        initial $fatal(1, "FAIL depth_range depth=%0d", D5);
    end

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] addr;
    logic [2:0] addr5;
    logic [4:0] addrw;

    logic [7:0] dout;
    logic       valid;
    logic [7:0] dout5;
    logic       valid5;
    logic [3:0] doutw;
    logic       validw;

    sp_rom dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_addr  (addr),
        .o_dout  (dout),
        .o_valid (valid)
    );

    sp_rom #(.DEPTH(D5)) dut5 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_addr  (addr5),
        .o_dout  (dout5),
        .o_valid (valid5)
    );

    sp_rom #(.ADDR_W(W_AW), .DATA_W(W_DW)) dutw (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_addr  (addrw),
        .o_dout  (doutw),
        .o_valid (validw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string tag, input logic [7:0] d, input logic v);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [7:0] ad, input logic av);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty dout=%h valid=%b", ad, av);
        end else begin
            e = sb.pop_front();
            assert ({ad, av} === {e.d, e.v}) else begin
                errors++;
                $error("FAIL %s dout=%h valid=%b expected dout=%h valid=%b",
                       e.tag, ad, av, e.d, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tbl5 [8];
    logic [31:0] wfull;

    initial begin
        tbl5[0] = 8'h00; tbl5[1] = 8'h01; tbl5[2] = 8'h02; tbl5[3] = 8'h03;
        tbl5[4] = 8'h04; tbl5[5] = 8'h00; tbl5[6] = 8'h00; tbl5[7] = 8'h00;

        rst   = 1'b0;
        en    = 1'b1;
        addr  = 3'd5;
        addr5 = 3'd0;
        addrw = 5'd0;
        tick();
        tick();

        // Asynchronous reset with a real word held
        #3 rst = 1'b1;
        #1;
        expect_out("rst_async", 8'h00, 1'b0);
        compare(dout, valid);
        en = 1'b0;
        #1;
        expect_out("rst_async_en0", 8'h00, 1'b0);
        compare(dout, valid);
        en = 1'b1;
        tick();
        expect_out("rst_hold_edge", 8'h00, 1'b0);
        compare(dout, valid);
        #2 rst = 1'b0;
        #1;
        expect_out("rel_no_edge", 8'h00, 1'b0);
        compare(dout, valid);
        tick();
        expect_out("rel_first_edge", 8'h05, 1'b1);
        compare(dout, valid);

        // Disabled reads, then enable mid-cycle
        addr = 3'd1;
        en   = 1'b0;
        tick();
        expect_out("dis_c1", 8'h00, 1'b0);
        compare(dout, valid);
        tick();
        expect_out("dis_c2", 8'h00, 1'b0);
        compare(dout, valid);
        #2 en = 1'b1;
        #1;
        expect_out("en_rise_same_cycle", 8'h01, 1'b1);
        compare(dout, valid);

        // Sweep 2..7, each held two cycles
        for (int a = 2; a <= 7; a++) begin
            addr = 3'(a);
            #1;
            expect_out("sweep_pre_edge", 8'(a - 1), 1'b1);
            compare(dout, valid);
            tick();
            expect_out("sweep_edge1", 8'(a), 1'b1);
            compare(dout, valid);
            tick();
            expect_out("sweep_edge2", 8'(a), 1'b1);
            compare(dout, valid);
        end

        // Mid-cycle address change 3 -> 6
        addr = 3'd3;
        tick();
        expect_out("mid_a3", 8'h03, 1'b1);
        compare(dout, valid);
        #2 addr = 3'd6;
        #1;
        expect_out("mid_hold3", 8'h03, 1'b1);
        compare(dout, valid);
        tick();
        expect_out("mid_a6", 8'h06, 1'b1);
        compare(dout, valid);

        // Reset mid-sweep at address 4
        addr = 3'd4;
        tick();
        expect_out("rst_mid_a4", 8'h04, 1'b1);
        compare(dout, valid);
        #2 rst = 1'b1;
        #1;
        expect_out("rst_mid_async", 8'h00, 1'b0);
        compare(dout, valid);
        #2 rst = 1'b0;
        tick();
        expect_out("rst_mid_return", 8'h04, 1'b1);
        compare(dout, valid);

        // Address change and enable rise in the same cycle
        en   = 1'b0;
        addr = 3'd2;
        tick();
        addr = 3'd5;
        en   = 1'b1;
        #1;
        expect_out("addr_en_same_cycle", 8'h02, 1'b1);
        compare(dout, valid);
        tick();
        expect_out("addr_en_next_edge", 8'h05, 1'b1);
        compare(dout, valid);

        // Back-to-back, one new address per cycle
        for (int a = 7; a >= 0; a--) begin
            addr = 3'(a);
            tick();
            expect_out("b2b", 8'(a), 1'b1);
            compare(dout, valid);
        end

        // DEPTH=5 instance: addresses past the populated range read zero
        for (int a = 0; a < 8; a++) begin
            addr5 = 3'(a);
            tick();
            expect_out("depth5", tbl5[a], 1'b1);
            compare(dout5, valid5);
        end

        // Narrow-word instance: content truncates to 4 bits
        addrw = 5'd20;
        tick();
        expect_out("trunc_w20", 8'h04, 1'b1);
        compare({4'h0, doutw}, validw);
        addrw = 5'd31;
        tick();
        expect_out("trunc_w31", 8'h0f, 1'b1);
        compare({4'h0, doutw}, validw);
        for (int a = 0; a < 32; a++) begin
            addrw = 5'(a);
            tick();
            wfull = rom_word(32'(a), 32);
            expect_out("trunc_sweep", {4'h0, wfull[3:0]}, 1'b1);
            compare({4'h0, doutw}, validw);
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover entries=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
